// File: rtl/acc_mem_pkg.sv
// rtl/acc_mem_pkg.sv - shared widths and FSM state type for the accelerator memory responder.
package acc_mem_pkg;

  localparam int ACC_ADDR_SIZE  = 16;
  localparam int ACC_WORD_SIZE  = 32;
  localparam int ACC_LINE_SIZE  = 512;
  localparam int WORDS_PER_LINE = ACC_LINE_SIZE / ACC_WORD_SIZE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RESP_RD = 3'd2,
    WR      = 3'd3,
    RESP_WR = 3'd4
  } state_t;

endpackage

// File: rtl/acc_mem_responder_if.sv
// rtl/acc_mem_responder_if.sv - accelerator-side line read / word write request interface.
interface acc_mem_responder_if
  import acc_mem_pkg::*;
#(
  parameter int ADDR_SIZE = ACC_ADDR_SIZE,
  parameter int WORD_SIZE = ACC_WORD_SIZE,
  parameter int LINE_SIZE = ACC_LINE_SIZE
);

  logic                 acc_read_en;
  logic [ADDR_SIZE-1:0] acc_read_addr;
  logic [LINE_SIZE-1:0] acc_read_data;
  logic                 acc_read_data_valid;
  logic                 acc_write_en;
  logic [ADDR_SIZE-1:0] acc_write_addr;
  logic [WORD_SIZE-1:0] acc_write_data;
  logic                 acc_write_done;

  modport master (
    output acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
    input  acc_read_data, acc_read_data_valid, acc_write_done
  );

  modport slave (
    input  acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
    output acc_read_data, acc_read_data_valid, acc_write_done
  );

endinterface

// File: rtl/acc_line_assembler.sv
// rtl/acc_line_assembler.sv - places captured SRAM words into a line register by word index.
// Word 0 lands in the most significant slot; the line is only cleared by reset.
module acc_line_assembler #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 512,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IDX_W-1:0]     idx,
  input  logic [WORD_SIZE-1:0] word,
  output logic [LINE_SIZE-1:0] line
);

  logic [LINE_SIZE-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d[LINE_SIZE-1-WORD_SIZE*int'(idx) -: WORD_SIZE] = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/acc_mem_responder.sv
// rtl/acc_mem_responder.sv - serves 512-bit line reads and 32-bit word writes over a 32-bit SRAM port.
// Optional macro ACC_MEM_CPU_ARB_EN adds cpu_mem_busy, which stalls SRAM issue while the CPU owns the port.
module acc_mem_responder
  import acc_mem_pkg::*;
#(
  parameter int ADDR_SIZE = ACC_ADDR_SIZE,
  parameter int WORD_SIZE = ACC_WORD_SIZE,
  parameter int LINE_SIZE = ACC_LINE_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_mem_responder_if.slave   acc,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [WORD_SIZE-1:0] sram_wdata,
  input  logic [WORD_SIZE-1:0] sram_rdata,
  output logic                 busy
`ifdef ACC_MEM_CPU_ARB_EN
  ,
  input  logic                 cpu_mem_busy
`endif
);

  localparam int WPL   = LINE_SIZE / WORD_SIZE;
  localparam int IDX_W = $clog2(WPL);

  state_t               state_q, state_d;
  logic [IDX_W:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
  logic                 sram_en_q, sram_en_d;
  logic                 sram_we_q, sram_we_d;
  logic [ADDR_SIZE-1:0] sram_addr_q, sram_addr_d;
  logic [WORD_SIZE-1:0] sram_wdata_q, sram_wdata_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cap_load;
  logic                 stall;

`ifdef ACC_MEM_CPU_ARB_EN
  assign stall = cpu_mem_busy;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_idx_d    = cap_idx_q;
    base_d       = base_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = '0;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    cap_load     = 1'b0;
    // A read strobe visible now returns data next cycle; capture then, even during a stall.
    rd_pend_d    = sram_en_q & ~sram_we_q;

    case (state_q)
      IDLE: begin
        if (acc.acc_read_en) begin
          base_d    = acc.acc_read_addr;
          cnt_d     = '0;
          cap_idx_d = '0;
          state_d   = RD;
        end else if (acc.acc_write_en) begin
          wr_addr_d = acc.acc_write_addr;
          wr_data_d = acc.acc_write_data;
          state_d   = WR;
        end
      end
      RD: begin
        if (cnt_q < (IDX_W+1)'(WPL) && !stall) begin
          sram_en_d   = 1'b1;
          sram_addr_d = base_q + ADDR_SIZE'(cnt_q);
          cnt_d       = cnt_q + 1'b1;
        end
        if (rd_pend_q) begin
          cap_load  = 1'b1;
          cap_idx_d = cap_idx_q + 1'b1;
          if (cap_idx_q == IDX_W'(WPL-1)) begin
            valid_d = 1'b1;
            state_d = RESP_RD;
          end
        end
      end
      RESP_RD: state_d = IDLE;
      WR: begin
        if (!stall) begin
          sram_en_d    = 1'b1;
          sram_we_d    = 1'b1;
          sram_addr_d  = wr_addr_q;
          sram_wdata_d = wr_data_q;
          state_d      = RESP_WR;
        end
      end
      RESP_WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_idx_q    <= '0;
      rd_pend_q    <= 1'b0;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_idx_q    <= cap_idx_d;
      rd_pend_q    <= rd_pend_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  acc_line_assembler #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_SIZE (LINE_SIZE),
    .IDX_W     (IDX_W)
  ) u_line (
    .clk  (clk),
    .rst  (rst),
    .load (cap_load),
    .idx  (cap_idx_q),
    .word (sram_rdata),
    .line (acc.acc_read_data)
  );

  assign acc.acc_read_data_valid = valid_q;
  assign acc.acc_write_done      = done_q;
  assign sram_en                 = sram_en_q;
  assign sram_we                 = sram_we_q;
  assign sram_addr               = sram_addr_q;
  assign sram_wdata              = sram_wdata_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_acc_mem_responder.sv
// tb/tb_acc_mem_responder.sv - directed self-checking bench for acc_mem_responder.
module tb_acc_mem_responder;
  import acc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_en, sram_we, busy;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        cpu_mem_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [0:65535];
  logic [15:0] s_addr [$];
  int          s_cyc [$];
  logic        s_we [$];
  logic [31:0] s_wdata [$];
  int          v_cyc [$];
  int          d_cyc [$];

  always #5 clk = ~clk;

  acc_mem_responder_if acc_if ();

  acc_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .acc        (acc_if.slave),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
`ifdef ACC_MEM_CPU_ARB_EN
    ,
    .cpu_mem_busy (cpu_mem_busy)
`endif
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    if (sram_en) begin
      s_addr.push_back(sram_addr);
      s_cyc.push_back(cyc);
      s_we.push_back(sram_we);
      s_wdata.push_back(sram_wdata);
    end
    if (acc_if.acc_read_data_valid) v_cyc.push_back(cyc);
    if (acc_if.acc_write_done)      d_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    s_addr.delete(); s_cyc.delete(); s_we.delete(); s_wdata.delete();
    v_cyc.delete(); d_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({sram_en, sram_we, busy, acc_if.acc_read_data_valid, acc_if.acc_write_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {sram_en, sram_we, busy,
               acc_if.acc_read_data_valid, acc_if.acc_write_done});
    end
    checks++;
    if (sram_addr !== 16'h0 || sram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus addr %h wdata %h want 0", sram_addr, sram_wdata);
    end
    checks++;
    if (acc_if.acc_read_data !== 512'h0) begin
      errors++;
      $display("FAIL reset_line got %h want 0", acc_if.acc_read_data);
    end
    rst = 1'b0;
  endtask

  // Checks strobes, capture order and valid timing of one read; stall cycles shift the tail.
  task automatic check_read(input string name, input logic [15:0] base, input int t, input int stall_cyc);
    logic [31:0] w;
    checks++;
    if (v_cyc.size() != 1 || v_cyc[0] != t + 18 + stall_cyc) begin
      errors++;
      $display("FAIL %s_valid pulses %0d first at %0d want 1 at %0d", name, v_cyc.size(),
               (v_cyc.size() > 0) ? v_cyc[0] - t : -1, 18 + stall_cyc);
    end
    checks++;
    if (s_addr.size() < 16) begin
      errors++;
      $display("FAIL %s_strobes got %0d want 16", name, s_addr.size());
    end
    for (int k = 0; k < 16 && k < s_addr.size(); k++) begin
      checks++;
      if (s_addr[k] !== 16'(base + k) || s_we[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s_addr%0d got %h we %b want %h we 0", name, k, s_addr[k], s_we[k], 16'(base + k));
      end
      if (stall_cyc == 0) begin
        checks++;
        if (s_cyc[k] != t + 1 + k) begin
          errors++;
          $display("FAIL %s_strobe_time%0d got T+%0d want T+%0d", name, k, s_cyc[k] - t, 1 + k);
        end
      end
      w = acc_if.acc_read_data[511-32*k -: 32];
      checks++;
      if (w !== {16'h0, 16'(base + k)}) begin
        errors++;
        $display("FAIL %s_word%0d got %h want %h", name, k, w, {16'h0, 16'(base + k)});
      end
    end
  endtask

  task automatic test_read(input string name, input logic [15:0] base);
    int t;
    @(negedge clk);
    clear_logs();
    acc_if.acc_read_en   = 1'b1;
    acc_if.acc_read_addr = base;
    t = cyc + 1;
    @(negedge clk);
    acc_if.acc_read_en = 1'b0;
    repeat (22) @(negedge clk);
    #1;
    check_read(name, base, t, 0);
  endtask

  task automatic test_write();
    int t;
    @(negedge clk);
    clear_logs();
    acc_if.acc_write_en   = 1'b1;
    acc_if.acc_write_addr = 16'h5010;
    acc_if.acc_write_data = 32'h1234_5678;
    t = cyc + 1;
    @(negedge clk);
    acc_if.acc_write_en = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (s_addr.size() != 1 || s_we[0] !== 1'b1 || s_addr[0] !== 16'h5010 ||
        s_wdata[0] !== 32'h1234_5678 || s_cyc[0] != t + 1) begin
      errors++;
      $display("FAIL write_strobe count %0d (want 1 we=1 @5010 data 12345678 at T+1)", s_addr.size());
    end
    checks++;
    if (d_cyc.size() != 1 || d_cyc[0] != t + 2) begin
      errors++;
      $display("FAIL write_done pulses %0d want 1 at T+2", d_cyc.size());
    end
    checks++;
    if (mem[16'h5010] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_mem got %h want 12345678", mem[16'h5010]);
    end
    checks++;
    if (sram_we !== 1'b0 || sram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL write_idle_bus we %b wdata %h want 0 0", sram_we, sram_wdata);
    end
  endtask

  task automatic test_read_write_collision();
    int t;
    @(negedge clk);
    clear_logs();
    acc_if.acc_read_en    = 1'b1;
    acc_if.acc_read_addr  = 16'h0100;
    acc_if.acc_write_en   = 1'b1;
    acc_if.acc_write_addr = 16'h0200;
    acc_if.acc_write_data = 32'hCAFE_BABE;
    t = cyc + 1;
    @(negedge clk);
    acc_if.acc_read_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (acc_if.acc_write_done) acc_if.acc_write_en = 1'b0;
    end
    acc_if.acc_write_en = 1'b0;
    #1;
    check_read("both_rd", 16'h0100, t, 0);
    checks++;
    if (s_addr.size() != 17 || s_we[16] !== 1'b1 || s_addr[16] !== 16'h0200 || s_cyc[16] != t + 21) begin
      errors++;
      $display("FAIL both_wr_strobe count %0d want 17 with write @0200 at T+21", s_addr.size());
    end
    checks++;
    if (d_cyc.size() != 1 || d_cyc[0] != t + 22) begin
      errors++;
      $display("FAIL both_wr_done pulses %0d at T+%0d want 1 at T+22", d_cyc.size(),
               (d_cyc.size() > 0) ? d_cyc[0] - t : -1);
    end
    checks++;
    if (mem[16'h0200] !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL both_wr_mem got %h want cafebabe", mem[16'h0200]);
    end
  endtask

  task automatic test_reset_mid_read();
    bit hit = 0;
    @(negedge clk);
    clear_logs();
    acc_if.acc_read_en   = 1'b1;
    acc_if.acc_read_addr = 16'h0400;
    @(negedge clk);
    acc_if.acc_read_en = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (sram_en && sram_addr == 16'h0407) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_issue7 got no strobe @0407 want one within 20 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sram_en, sram_we, busy, acc_if.acc_read_data_valid} !== 4'b0 ||
        acc_if.acc_read_data !== 512'h0 || sram_addr !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs en %b we %b busy %b addr %h want all 0", sram_en, sram_we, busy, sram_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (25) @(negedge clk);
    checks++;
    if (v_cyc.size() != 0 || s_addr.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet valid %0d strobes %0d want 0 0", v_cyc.size(), s_addr.size());
    end
    test_read("after_rst", 16'h0300);
  endtask

`ifdef ACC_MEM_CPU_ARB_EN
  task automatic test_cpu_arb();
    int t;
    @(negedge clk);
    clear_logs();
    acc_if.acc_read_en   = 1'b1;
    acc_if.acc_read_addr = 16'h0600;
    t = cyc + 1;
    @(negedge clk);
    acc_if.acc_read_en = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    cpu_mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    cpu_mem_busy = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_read("arb", 16'h0600, t, 3);
    for (int k = 0; k < s_cyc.size(); k++) begin
      checks++;
      if (s_cyc[k] >= t + 6 && s_cyc[k] <= t + 8) begin
        errors++;
        $display("FAIL arb_stall_strobe%0d got strobe at T+%0d want none in T+6..T+8", k, s_cyc[k] - t);
      end
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = a;
    acc_if.acc_read_en    = 1'b0;
    acc_if.acc_read_addr  = '0;
    acc_if.acc_write_en   = 1'b0;
    acc_if.acc_write_addr = '0;
    acc_if.acc_write_data = '0;
    test_reset();
    test_read("rd5008", 16'h5008);
    test_write();
    test_read_write_collision();
    test_read("rdfff8", 16'hFFF8);
    test_reset_mid_read();
`ifdef ACC_MEM_CPU_ARB_EN
    test_cpu_arb();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
